sdram_cmd_fifo: RTL and testbench



---
 rtl/sdram_cmd_fifo.sv | 52 +++++
 tb/tb_sdram_cmd_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_fifo.sv
// sdram_cmd_fifo: show-ahead command FIFO for the SDRAM controller plus a 3-flop input synchronizer
module sdram_cmd_fifo #(
  parameter int DATA_W     = 44,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  wrreq,
  input  logic [DATA_W-1:0]     data,
  input  logic                  rdreq,
  output logic [DATA_W-1:0]     q,
  output logic                  rdempty,
  output logic                  wrfull,
  output logic [DEPTH_LOG2:0]   usedw,
  input  logic                  async_in,
  output logic                  sync_out
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   count;
  logic [2:0]            sync;
  logic                  push, pop;
  assign rdempty  = count == '0;
  assign wrfull   = count == CNT_FULL;
  assign usedw    = count;
  assign q        = mem[rptr];
  assign sync_out = sync[2];
  assign push     = wrreq && !wrfull;
  assign pop      = rdreq && !rdempty;
  // memory is cleared too so q reads 0, never X, straight after reset
  always_ff @(posedge clock or posedge aclr)
    if (aclr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      sync  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= data;
        wptr      <= wptr + PTR_ONE;
      end
      if (pop) rptr <= rptr + PTR_ONE;
      if (push && !pop) count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      sync <= {sync[1:0], async_in};
    end
endmodule

// File: tb/tb_sdram_cmd_fifo.sv
// tb_sdram_cmd_fifo: randomized and directed checks of sdram_cmd_fifo against a queue model
module tb_sdram_cmd_fifo;
  logic        clock = 0;
  logic        aclr = 0;
  logic        wrreq = 0;
  logic [43:0] data = '0;
  logic        rdreq = 0;
  logic [43:0] q;
  logic        rdempty, wrfull;
  logic [4:0]  usedw;
  logic        async_in = 0;
  logic        sync_out;
  int          checks = 0;
  int          failures = 0;
  logic [43:0] mq[$];
  bit          hist[$];

  sdram_cmd_fifo #(.DATA_W(44), .DEPTH_LOG2(4)) dut (
    .clock(clock), .aclr(aclr), .wrreq(wrreq), .data(data), .rdreq(rdreq),
    .q(q), .rdempty(rdempty), .wrfull(wrfull), .usedw(usedw),
    .async_in(async_in), .sync_out(sync_out)
  );

  always #5 clock = ~clock;

  // one clock edge: the model applies the FIFO rules to the inputs seen at the edge
  task automatic tick();
    bit p, r;
    @(posedge clock);
    p = wrreq && mq.size() < 16;
    r = rdreq && mq.size() > 0;
    if (r) void'(mq.pop_front());
    if (p) mq.push_back(data);
    hist.push_back(async_in);
    void'(hist.pop_front());
    #1;
  endtask

  task automatic model_clear();
    mq.delete();
    hist = '{0, 0, 0};
  endtask

  task automatic test_reset();
    aclr = 1;
    #2;
    model_clear();
    checks += 5;
    if (rdempty !== 1'b1) begin failures++; $display("FAIL reset_rdempty got=%b exp=1", rdempty); end
    if (wrfull !== 1'b0) begin failures++; $display("FAIL reset_wrfull got=%b exp=0", wrfull); end
    if (usedw !== 5'd0) begin failures++; $display("FAIL reset_usedw got=%0d exp=0", usedw); end
    if (q !== 44'h0) begin failures++; $display("FAIL reset_q got=%h exp=0", q); end
    if (sync_out !== 1'b0) begin failures++; $display("FAIL reset_sync got=%b exp=0", sync_out); end
    #2 aclr = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_single();
    wrreq = 1; data = 44'h0000001_ABCD;
    tick();
    wrreq = 0;
    checks += 3;
    if (rdempty !== 1'b0) begin failures++; $display("FAIL single_rdempty got=%b exp=0", rdempty); end
    if (usedw !== 5'd1) begin failures++; $display("FAIL single_usedw got=%0d exp=1", usedw); end
    if (q !== 44'h0000001_ABCD) begin failures++; $display("FAIL single_q got=%h exp=0000001abcd", q); end
    rdreq = 1;
    tick();
    rdreq = 0;
    checks += 2;
    if (rdempty !== 1'b1) begin failures++; $display("FAIL single_pop_rdempty got=%b exp=1", rdempty); end
    if (usedw !== 5'd0) begin failures++; $display("FAIL single_pop_usedw got=%0d exp=0", usedw); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      wrreq = 1; data = 44'(i);
      tick();
    end
    checks += 2;
    if (wrfull !== 1'b1) begin failures++; $display("FAIL fill_wrfull got=%b exp=1", wrfull); end
    if (usedw !== 5'd16) begin failures++; $display("FAIL fill_usedw got=%0d exp=16", usedw); end
    data = 44'h11;
    tick();
    wrreq = 0;
    checks++;
    if (usedw !== 5'd16) begin failures++; $display("FAIL overflow_usedw got=%0d exp=16", usedw); end
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (q !== 44'(i)) begin failures++; $display("FAIL fill_order[%0d] got=%h exp=%h", i, q, 44'(i)); end
      rdreq = 1;
      tick();
    end
    rdreq = 0;
    checks += 2;
    if (rdempty !== 1'b1) begin failures++; $display("FAIL drain_rdempty got=%b exp=1", rdempty); end
    if (usedw !== 5'd0) begin failures++; $display("FAIL drain_usedw got=%0d exp=0", usedw); end
  endtask

  task automatic test_simul();
    logic [43:0] v;
    for (int i = 0; i < 3; i++) begin
      wrreq = 1; data = 44'({$urandom(), $urandom()});
      tick();
    end
    data = 44'({$urandom(), $urandom()});
    rdreq = 1;
    tick();
    wrreq = 0; rdreq = 0;
    checks++;
    if (usedw !== 5'd3) begin failures++; $display("FAIL simul_usedw got=%0d exp=3", usedw); end
    while (mq.size() > 0) begin
      v = mq[0];
      checks++;
      if (q !== v) begin failures++; $display("FAIL simul_order got=%h exp=%h", q, v); end
      rdreq = 1;
      tick();
    end
    tick();
    rdreq = 0;
    checks++;
    if (usedw !== 5'd0) begin failures++; $display("FAIL underflow_usedw got=%0d exp=0", usedw); end
    wrreq = 1; rdreq = 1; data = 44'h0BEEF_12345;
    tick();
    wrreq = 0; rdreq = 0;
    checks += 2;
    if (usedw !== 5'd1) begin failures++; $display("FAIL empty_simul_usedw got=%0d exp=1", usedw); end
    if (q !== 44'h0BEEF_12345) begin failures++; $display("FAIL empty_simul_q got=%h exp=0beef12345", q); end
    rdreq = 1;
    tick();
    rdreq = 0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) begin
      wrreq = 1; data = 44'(i);
      tick();
      wrreq = 0;
      checks++;
      if (q !== 44'(i) || usedw !== 5'd1) begin
        failures++; $display("FAIL wrap[%0d] q=%h usedw=%0d exp q=%h usedw=1", i, q, usedw, 44'(i));
      end
      rdreq = 1;
      tick();
      rdreq = 0;
    end
    checks++;
    if (rdempty !== 1'b1) begin failures++; $display("FAIL wrap_end_rdempty got=%b exp=1", rdempty); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wrreq = $urandom_range(0, 99) < (n < 200 ? 70 : 35);
      rdreq = $urandom_range(0, 99) < (n < 200 ? 35 : 70);
      data = 44'({$urandom(), $urandom()});
      async_in = $urandom_range(0, 1) == 1;
      tick();
      checks++;
      if (usedw !== 5'(mq.size()) || rdempty !== (mq.size() == 0) || wrfull !== (mq.size() == 16) ||
          (mq.size() > 0 && q !== mq[0]) || sync_out !== hist[0]) begin
        failures++;
        $display("FAIL random[%0d] usedw=%0d/%0d empty=%b full=%b q=%h exp_q=%h sync=%b/%b",
                 n, usedw, mq.size(), rdempty, wrfull, q, mq.size() > 0 ? mq[0] : 44'h0, sync_out, hist[0]);
      end
    end
    wrreq = 0; rdreq = 0;
  endtask

  task automatic test_sync_reset();
    async_in = 0;
    for (int i = 0; i < 4; i++) tick();
    async_in = 1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (sync_out !== (e >= 3)) begin failures++; $display("FAIL sync_edge%0d got=%b exp=%b", e, sync_out, e >= 3); end
    end
    while (mq.size() > 0) begin rdreq = 1; tick(); end
    rdreq = 0;
    for (int i = 0; i < 5; i++) begin
      wrreq = 1; data = 44'(100 + i);
      tick();
    end
    wrreq = 0;
    checks++;
    if (usedw !== 5'd5) begin failures++; $display("FAIL pre_reset_usedw got=%0d exp=5", usedw); end
    #2 aclr = 1;
    #1;
    model_clear();
    checks += 4;
    if (usedw !== 5'd0) begin failures++; $display("FAIL midreset_usedw got=%0d exp=0", usedw); end
    if (rdempty !== 1'b1) begin failures++; $display("FAIL midreset_rdempty got=%b exp=1", rdempty); end
    if (sync_out !== 1'b0) begin failures++; $display("FAIL midreset_sync got=%b exp=0", sync_out); end
    if (q !== 44'h0) begin failures++; $display("FAIL midreset_q got=%h exp=0", q); end
    aclr = 0; async_in = 0;
    @(posedge clock); #1;
    wrreq = 1; data = 44'h0000ABC_1234;
    tick();
    wrreq = 0;
    checks += 2;
    if (usedw !== 5'd1) begin failures++; $display("FAIL postreset_usedw got=%0d exp=1", usedw); end
    if (q !== 44'h0000ABC_1234) begin failures++; $display("FAIL postreset_q got=%h exp=0000abc1234", q); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_fill();
    test_simul();
    test_wrap();
    test_random();
    test_sync_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
